// File: rtl/rsa_encrypt_core.sv
// Iterative RSA encryption C = M^e mod n using right-to-left square-and-multiply with shift-add modmul.
// Define RSA_EARLY_EXIT_EN to stop once the exponent is exhausted; otherwise every run takes WIDTH iterations.
module rsa_encrypt_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             compute,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] C,
  output logic             encrypt_done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, REDUCE, MULT, UPDATE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] n_reg, exp_reg, base_reg, result_reg;
  logic [WIDTH-1:0] acc_p_reg, acc_s_reg, mul_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] c_fin;
`ifndef RSA_EARLY_EXIT_EN
  logic [CW-1:0]    iter_reg;
`endif

  // One MSB-first step of interleaved modular multiplication; r and a must already be below nm.
  function automatic logic [WIDTH-1:0] modmul_step(input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic             mbit,
                                                   input logic [WIDTH-1:0] nm);
    logic [WIDTH:0] t;
    logic [WIDTH:0] nn;
    nn = {1'b0, nm};
    t  = {r, 1'b0};
    if (t >= nn) t = t - nn;
    if (mbit) begin
      t = t + {1'b0, a};
      if (t >= nn) t = t - nn;
    end
    return t[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    c_fin      = '0;
    case (state_reg)
      IDLE:   if (compute) state_next = REDUCE;
      REDUCE: begin
        if (cnt_reg == '0) begin
`ifdef RSA_EARLY_EXIT_EN
          state_next = (exp_reg == '0) ? DONE : MULT;
`else
          state_next = MULT;
`endif
        end
        c_fin = (n_reg <= WIDTH'(1)) ? '0 : WIDTH'(1);
      end
      MULT:   if (cnt_reg == CW'(1)) state_next = UPDATE;
      UPDATE: begin
`ifdef RSA_EARLY_EXIT_EN
        state_next = ((exp_reg >> 1) == '0) ? DONE : MULT;
`else
        state_next = (iter_reg == CW'(WIDTH - 1)) ? DONE : MULT;
`endif
        if (n_reg > WIDTH'(1)) c_fin = exp_reg[0] ? acc_p_reg : result_reg;
      end
      DONE:   if (!compute) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg        <= '0;
      exp_reg      <= '0;
      base_reg     <= '0;
      result_reg   <= '0;
      acc_p_reg    <= '0;
      acc_s_reg    <= '0;
      mul_sh_reg   <= '0;
      cnt_reg      <= '0;
      C            <= '0;
      encrypt_done <= 1'b0;
`ifndef RSA_EARLY_EXIT_EN
      iter_reg     <= '0;
`endif
    end else begin
      encrypt_done <= (state_next == DONE);
      if (state_reg != DONE && state_next == DONE) C <= c_fin;
      case (state_reg)
        IDLE: if (compute) begin
          n_reg      <= n;
          exp_reg    <= e;
          mul_sh_reg <= M;
          acc_p_reg  <= '0;
          cnt_reg    <= CW'(WIDTH);
        end
        REDUCE: begin
          if (cnt_reg != '0) begin
            acc_p_reg  <= modmul_step(acc_p_reg, WIDTH'(1), mul_sh_reg[WIDTH-1], n_reg);
            mul_sh_reg <= mul_sh_reg << 1;
            cnt_reg    <= cnt_reg - CW'(1);
          end else begin
            // base = M mod n is ready; both products in MULT use base as multiplier.
            base_reg   <= acc_p_reg;
            mul_sh_reg <= acc_p_reg;
            result_reg <= WIDTH'(1);
            acc_p_reg  <= '0;
            acc_s_reg  <= '0;
            cnt_reg    <= CW'(WIDTH);
`ifndef RSA_EARLY_EXIT_EN
            iter_reg   <= '0;
`endif
          end
        end
        MULT: begin
          acc_p_reg  <= modmul_step(acc_p_reg, result_reg, mul_sh_reg[WIDTH-1], n_reg);
          acc_s_reg  <= modmul_step(acc_s_reg, base_reg, mul_sh_reg[WIDTH-1], n_reg);
          mul_sh_reg <= mul_sh_reg << 1;
          cnt_reg    <= cnt_reg - CW'(1);
        end
        UPDATE: begin
          if (exp_reg[0]) result_reg <= acc_p_reg;
          base_reg   <= acc_s_reg;
          mul_sh_reg <= acc_s_reg;
          exp_reg    <= exp_reg >> 1;
          acc_p_reg  <= '0;
          acc_s_reg  <= '0;
          cnt_reg    <= CW'(WIDTH);
`ifndef RSA_EARLY_EXIT_EN
          iter_reg   <= iter_reg + CW'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_encrypt_core.sv
// Scoreboard bench for rsa_encrypt_core: stimulus pushes expected C and latency, a monitor checks on encrypt_done rise.
module tb_rsa_encrypt_core;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         compute = 1'b0;
  logic [W-1:0] M = '0, e = '0, n = '0;
  logic [W-1:0] C;
  logic         encrypt_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_id = 0;

  typedef struct {
    logic [W-1:0] c;
    int           start;
    int           lat;
    int           id;
  } exp_t;
  exp_t sb[$];

  rsa_encrypt_core #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .compute(compute),
    .M(M), .e(e), .n(n), .C(C), .encrypt_done(encrypt_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input logic [W-1:0] ee);
    int k = 0;
    for (int i = 0; i < W; i++) if (ee[i]) k = i + 1;
`ifdef RSA_EARLY_EXIT_EN
    return (W + 1) * (k + 1);
`else
    return (W + 1) * (W + 1);
`endif
  endfunction

  function automatic logic [W-1:0] ref_exp(input logic [W-1:0] m, input logic [W-1:0] ee,
                                           input logic [W-1:0] nn);
    longint unsigned b, r, mm;
    if (nn <= 1) return '0;
    mm = nn;
    b = m % mm;
    r = 1;
    for (int i = 0; i < W; i++) begin
      if (ee[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return r[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  // Monitor: one pop per rising edge of encrypt_done.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (encrypt_done && !prev_done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got C=%0d expected no completion", C);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (C !== x.c || (cyc - x.start) != x.lat) begin
          errors++;
          $display("FAIL run%0d: got C=%0d lat=%0d expected C=%0d lat=%0d",
                   x.id, C, cyc - x.start, x.c, x.lat);
        end else
          $display("ok   run%0d: C=%0d lat=%0d", x.id, C, cyc - x.start);
      end
    end
    prev_done <= encrypt_done;
  end

  task automatic start_run(input logic [W-1:0] m, input logic [W-1:0] ee,
                           input logic [W-1:0] nn, input logic [W-1:0] expc);
    exp_t x;
    M = m; e = ee; n = nn; compute = 1'b1;
    run_id++;
    x.c = expc; x.start = cyc + 1; x.lat = exp_lat(ee); x.id = run_id;
    sb.push_back(x);
  endtask

  task automatic wait_done(input bit scramble);
    int t = 0;
    while (!encrypt_done && t < 3000) begin
      @(negedge clk);
      if (scramble) begin
        M = $urandom; e = $urandom; n = $urandom;
      end
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no encrypt_done after %0d cycles expected completion", t);
    end
  endtask

  task automatic finish_run(input logic [W-1:0] expc);
    compute = 1'b0;
    @(negedge clk);
    chk("done_drop", {31'b0, encrypt_done}, '0);
    chk("c_hold", C, expc);
  endtask

  task automatic full_run(input logic [W-1:0] m, input logic [W-1:0] ee,
                          input logic [W-1:0] nn, input logic [W-1:0] expc, input bit scramble);
    start_run(m, ee, nn, expc);
    @(negedge clk);
    wait_done(scramble);
    finish_run(expc);
  endtask

  initial begin
    int low;
    logic [W-1:0] rm, re, rn;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_c", C, '0);
    chk("reset_done", {31'b0, encrypt_done}, '0);

    // Hold compute after completion: no restart, outputs stable.
    start_run(65, 37, 16781, 16030);
    @(negedge clk);
    wait_done(1'b0);
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (!encrypt_done || C !== 16030) low++;
    end
    chk("hold_stable_glitches", low, 0);
    finish_run(16030);

    full_run(67, 71, 323, 135, 1'b0);
    full_run(16846, 37, 16781, 16030, 1'b0);
    full_run(5, 0, 16781, 1, 1'b0);
    full_run(5, 3, 1, 0, 1'b0);
    full_run(5, 3, 0, 0, 1'b0);
    full_run(12345, 65537, 1000000, ref_exp(12345, 65537, 1000000), 1'b0);

    // Reset mid-run, compute kept high so a fresh run follows.
    M = 65; e = 37; n = 16781; compute = 1'b1;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_c", C, '0);
    chk("midreset_done", {31'b0, encrypt_done}, '0);
    start_run(65, 37, 16781, 16030);
    @(negedge clk);
    wait_done(1'b0);
    finish_run(16030);

    full_run(67, 71, 323, 135, 1'b1);

    for (int i = 0; i < 20; i++) begin
      rm = $urandom;
      re = (i < 10) ? W'($urandom_range(0, 255)) : W'($urandom);
      rn = (i % 3 == 0) ? W'($urandom_range(2, 1000)) : W'($urandom);
      if (rn < 2) rn = rn + 2;
      full_run(rm, re, rn, ref_exp(rm, re, rn), i[0]);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_encrypt_core.md
Name: rsa_encrypt_core

Overview:
- Iterative RSA encryption engine. Computes C = M^e mod n for unsigned operands.
- Uses right-to-left binary square-and-multiply with interleaved shift-add modular multiplication. No wide multiplier, no Montgomery form, so any n ≥ 2 is valid, including even n.
- Sits behind a host or controller that drives operands, raises compute, and waits for encrypt_done.

Parameters:
- WIDTH, 32, operand and result width in bits for M, e, n and C.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- compute  in  1  level start request; sampled only in IDLE.
- M  in  WIDTH  plaintext.
- e  in  WIDTH  public exponent.
- n  in  WIDTH  modulus.
- C  out  WIDTH  ciphertext, registered.
- encrypt_done  out  1  result valid, registered.

Behaviour:
- Reset: state=IDLE, C=0, encrypt_done=0, all internal registers cleared. Reset mid-operation aborts immediately; no partial result is exposed.
- IDLE:
  - On a clock edge with compute=1, latch M, e, n into internal registers and go to REDUCE.
  - Inputs changing after this edge are ignored until the next start.
- REDUCE (WIDTH cycles): base = M mod n, computed as modmul(1, M).
  - Then result=1; exp=e.
  - If exp==0, go to DONE; else go to MULT.
- modmul(a,b), WIDTH cycles, one multiplier bit per cycle, MSB first:
  - R starts at 0.
  - Each cycle: R = 2R; if R ≥ n then R -= n.
  - Then, if b[i]: R = R + a; if R ≥ n then R -= n.
  - Intermediates are WIDTH+1 bits wide; requires a < n.
- MULT (WIDTH cycles): two modmul units run in parallel.
  - P = result*base mod n.
  - S = base*base mod n.
- UPDATE (1 cycle):
  - If exp[0]: result = P.
  - base = S; exp = exp >> 1.
  - If exp (after shift) == 0, go to DONE; else go to MULT.
- DONE:
  - C = result mod n. For n==1, C=0; for e==0 and n>1, C=1.
  - encrypt_done=1.
  - Hold while compute=1. When compute=0, return to IDLE; encrypt_done drops and C holds its value.
  - A new run needs compute low for at least one cycle, then high again.
- Latency: encrypt_done rises (WIDTH+1) + (WIDTH+1)·k clock edges after the start edge. k = number of significant bits of e (0 for e=0).
  - Example: e=37 (k=6), WIDTH=32 gives 231 edges.
- n==0 is illegal. The block must still terminate with C=0 and encrypt_done=1, with no hang.
- M ≥ n is legal; the result equals (M mod n)^e mod n.

Optional Feature:
- Macro RSA_EARLY_EXIT_EN.
- Defined: UPDATE leaves for DONE as soon as the remaining exponent is 0. Latency depends on e, as stated above.
- Undefined (constant-time build): always executes exactly WIDTH MULT/UPDATE iterations regardless of e.
  - Latency is fixed at (WIDTH+1)·(WIDTH+1) edges: 1089 for WIDTH=32.
  - Results are identical in both builds.

Test Plan:
- Reset 2 cycles. M=65, e=37, n=16781, compute=1 held → encrypt_done=1, C=16030, latency 231 (early exit). Hold compute 100 more cycles: C and encrypt_done stable, no restart.
- M=67, e=71, n=323 → C=135. Then compute=0 → encrypt_done=0 next cycle, C stays 135. Then compute=1 with M=16846, e=37, n=16781 → C=16030 (M ≥ n case).
- e=0, M=5, n=16781 → C=1 after 33 cycles. M=5, e=3, n=1 → C=0.
- Start M=65, e=37, n=16781. Assert reset at cycle 50 for 1 cycle → C=0, encrypt_done=0, state IDLE. Keep compute=1 after reset → run completes with C=16030.
- Change M, e, n every cycle during an active run → result matches the values latched at the start edge. Both builds (with and without RSA_EARLY_EXIT_EN) give identical C across 1000 random (M, e, n ≥ 2) vectors against a reference model.
